// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and load results onto the register-file write port.
// Optional statistics counters are enabled by defining WB_STATS_EN.
module wb_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [63:0] alu_val,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [63:0] mem_data,
  input  logic [2:0]  mem_funct3,
  input  logic [2:0]  mem_offset,
  output logic        mem_ready,
  output logic        write_sig,
  output logic [4:0]  write_reg,
  output logic [63:0] write_val
`ifdef WB_STATS_EN
  ,
  output logic [CNT_W-1:0] alu_wr_count,
  output logic [CNT_W-1:0] mem_wr_count
`endif
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // Handshake: a source transfers when valid && ready in the same cycle; ready
  // depends only on valid, reset and the starvation counter, never on data.
  logic [3:0]  starve_q, starve_d;
  logic        alu_win;
  logic        alu_xfer, mem_xfer;
  logic        load_ok;
  logic [63:0] load_val;
  logic [63:0] byte_sh, half_sh, word_sh;
  logic        wr_en_d;
  logic [4:0]  wr_reg_d;
  logic [63:0] wr_val_d;
  logic        write_sig_q;
  logic [4:0]  write_reg_q;
  logic [63:0] write_val_q;

  assign alu_win   = alu_valid && (!mem_valid || (starve_q == LIMIT));
  assign alu_ready = !reset && alu_win;
  assign mem_ready = !reset && mem_valid && !alu_win;
  assign alu_xfer  = alu_valid && alu_ready;
  assign mem_xfer  = mem_valid && mem_ready;

  always_comb begin
    starve_d = starve_q;
    if (!alu_valid || alu_xfer) begin
      starve_d = 4'd0;
    end else if (starve_q != LIMIT) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Lane shifts drop the offset bits below the access size.
  assign byte_sh = mem_data >> {mem_offset, 3'b000};
  assign half_sh = mem_data >> {mem_offset[2:1], 4'b0000};
  assign word_sh = mem_data >> {mem_offset[2], 5'b00000};

  always_comb begin
    load_ok  = 1'b1;
    load_val = mem_data;
    case (mem_funct3)
      3'b000:  load_val = {{56{byte_sh[7]}}, byte_sh[7:0]};
      3'b100:  load_val = {56'd0, byte_sh[7:0]};
      3'b001:  load_val = {{48{half_sh[15]}}, half_sh[15:0]};
      3'b101:  load_val = {48'd0, half_sh[15:0]};
      3'b010:  load_val = {{32{word_sh[31]}}, word_sh[31:0]};
      3'b110:  load_val = {32'd0, word_sh[31:0]};
      3'b011:  load_val = mem_data;
      default: load_ok  = 1'b0;
    endcase
  end

  always_comb begin
    wr_en_d  = 1'b0;
    wr_reg_d = write_reg_q;
    wr_val_d = write_val_q;
    if (alu_xfer) begin
      wr_en_d  = (alu_rd != 5'd0);
      wr_reg_d = alu_rd;
      wr_val_d = alu_val;
    end else if (mem_xfer) begin
      wr_en_d  = (mem_rd != 5'd0) && load_ok;
      wr_reg_d = mem_rd;
      wr_val_d = load_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q    <= 4'd0;
      write_sig_q <= 1'b0;
      write_reg_q <= 5'd0;
      write_val_q <= 64'd0;
    end else begin
      starve_q    <= starve_d;
      write_sig_q <= wr_en_d;
      // Filtered transfers (x0, illegal funct3) leave the data registers untouched.
      if (wr_en_d) begin
        write_reg_q <= wr_reg_d;
        write_val_q <= wr_val_d;
      end
    end
  end

  assign write_sig = write_sig_q;
  assign write_reg = write_reg_q;
  assign write_val = write_val_q;

`ifdef WB_STATS_EN
  logic             src_alu_q;
  logic [CNT_W-1:0] alu_cnt_q, mem_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      src_alu_q <= 1'b0;
      alu_cnt_q <= '0;
      mem_cnt_q <= '0;
    end else begin
      if (wr_en_d) begin
        src_alu_q <= alu_xfer;
      end
      if (write_sig_q && src_alu_q && (alu_cnt_q != '1)) begin
        alu_cnt_q <= alu_cnt_q + 1'b1;
      end
      if (write_sig_q && !src_alu_q && (mem_cnt_q != '1)) begin
        mem_cnt_q <= mem_cnt_q + 1'b1;
      end
    end
  end

  assign alu_wr_count = alu_cnt_q;
  assign mem_wr_count = mem_cnt_q;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter: inputs change 1ns after the
// rising edge, all observations are taken on the falling edge.
module tb_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [63:0] alu_val;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [63:0] mem_data;
  logic [2:0]  mem_funct3;
  logic [2:0]  mem_offset;
  logic        mem_ready;
  logic        write_sig;
  logic [4:0]  write_reg;
  logic [63:0] write_val;
`ifdef WB_STATS_EN
  logic [31:0] alu_wr_count;
  logic [31:0] mem_wr_count;
`endif

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

  wb_arbiter #(.STARVE_LIMIT(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_val(alu_val), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
    .mem_funct3(mem_funct3), .mem_offset(mem_offset), .mem_ready(mem_ready),
    .write_sig(write_sig), .write_reg(write_reg), .write_val(write_val)
`ifdef WB_STATS_EN
    , .alu_wr_count(alu_wr_count), .mem_wr_count(mem_wr_count)
`endif
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    alu_valid = 1'b0; alu_rd = 5'd0; alu_val = 64'd0;
    mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 64'd0;
    mem_funct3 = 3'b011; mem_offset = 3'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_val = 64'h77;
    mem_valid = 1'b1; mem_rd = 5'd8; mem_data = 64'h88;
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL reset_alu_ready got=%b exp=0", alu_ready); end
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL reset_mem_ready got=%b exp=0", mem_ready); end
    checks++; if (write_sig !== 1'b0) begin errors++; $display("FAIL reset_write_sig got=%b exp=0", write_sig); end
    checks++; if (write_reg !== 5'd0) begin errors++; $display("FAIL reset_write_reg got=%0d exp=0", write_reg); end
    checks++; if (write_val !== 64'd0) begin errors++; $display("FAIL reset_write_val got=%h exp=0", write_val); end
    next_cycle();
    drive_idle();
    reset = 1'b0;
  endtask

  task automatic test_single_alu();
    next_cycle();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_val = 64'h1234;
    @(negedge clk);
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL single_alu_ready got=%b exp=1", alu_ready); end
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL single_mem_ready got=%b exp=0", mem_ready); end
    next_cycle();
    alu_valid = 1'b0;
    @(negedge clk);
    checks++; if (write_sig !== 1'b1) begin errors++; $display("FAIL single_write_sig got=%b exp=1", write_sig); end
    checks++; if (write_reg !== 5'd5) begin errors++; $display("FAIL single_write_reg got=%0d exp=5", write_reg); end
    checks++; if (write_val !== 64'h1234) begin errors++; $display("FAIL single_write_val got=%h exp=1234", write_val); end
    next_cycle();
    @(negedge clk);
    checks++; if (write_sig !== 1'b0) begin errors++; $display("FAIL single_write_sig_drop got=%b exp=0", write_sig); end
    checks++; if (write_val !== 64'h1234) begin errors++; $display("FAIL single_write_val_hold got=%h exp=1234", write_val); end
  endtask

  task automatic test_load_extraction();
    logic [2:0]  f3_tab[8]  = '{3'b000, 3'b100, 3'b101, 3'b010, 3'b011, 3'b001, 3'b110, 3'b001};
    logic [2:0]  off_tab[8] = '{3'd7, 3'd7, 3'd2, 3'd4, 3'd5, 3'd6, 3'd4, 3'd3};
    logic [63:0] exp_tab[8] = '{64'hFFFF_FFFF_FFFF_FF88, 64'h88, 64'h4433,
                                64'hFFFF_FFFF_8877_6655, 64'h8877_6655_4433_2211,
                                64'hFFFF_FFFF_FFFF_8877, 64'h8877_6655, 64'h4433};
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 64'h8877_6655_4433_2211;
      mem_funct3 = f3_tab[i]; mem_offset = off_tab[i];
      @(negedge clk);
      checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL load_ready[%0d] got=%b exp=1", i, mem_ready); end
      next_cycle();
      mem_valid = 1'b0;
      @(negedge clk);
      checks++; if (write_sig !== 1'b1) begin errors++; $display("FAIL load_write_sig[%0d] got=%b exp=1", i, write_sig); end
      checks++; if (write_reg !== 5'd3) begin errors++; $display("FAIL load_write_reg[%0d] got=%0d exp=3", i, write_reg); end
      checks++; if (write_val !== exp_tab[i]) begin errors++; $display("FAIL load_val[%0d] f3=%b off=%0d got=%h exp=%h", i, f3_tab[i], off_tab[i], write_val, exp_tab[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] v;
    logic [63:0] exp_v;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      v = {$urandom, $urandom};
      alu_valid = 1'b1; alu_rd = 5'(i + 1); alu_val = v;
      exp_q.push_back(v);
      @(negedge clk);
      checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, alu_ready); end
      if (i > 0) begin
        exp_v = exp_q.pop_front();
        checks++; if (write_sig !== 1'b1) begin errors++; $display("FAIL b2b_write_sig[%0d] got=%b exp=1", i, write_sig); end
        checks++; if (write_reg !== 5'(i)) begin errors++; $display("FAIL b2b_write_reg[%0d] got=%0d exp=%0d", i, write_reg, i); end
        checks++; if (write_val !== exp_v) begin errors++; $display("FAIL b2b_write_val[%0d] got=%h exp=%h", i, write_val, exp_v); end
      end
    end
    next_cycle();
    alu_valid = 1'b0;
    @(negedge clk);
    exp_v = exp_q.pop_front();
    checks++; if (write_sig !== 1'b1) begin errors++; $display("FAIL b2b_last_sig got=%b exp=1", write_sig); end
    checks++; if (write_val !== exp_v) begin errors++; $display("FAIL b2b_last_val got=%h exp=%h", write_val, exp_v); end
  endtask

  task automatic test_starvation();
    logic exp_alu;
    logic prev_alu;
    prev_alu = 1'b0;
    next_cycle();
    alu_valid = 1'b1; alu_rd = 5'd10; alu_val = 64'hA;
    mem_valid = 1'b1; mem_rd = 5'd11; mem_data = 64'h55; mem_funct3 = 3'b011;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exp_alu = (k == 4);
      checks++; if (alu_ready !== exp_alu) begin errors++; $display("FAIL starve_alu_ready[%0d] got=%b exp=%b", k, alu_ready, exp_alu); end
      checks++; if (mem_ready !== !exp_alu) begin errors++; $display("FAIL starve_mem_ready[%0d] got=%b exp=%b", k, mem_ready, !exp_alu); end
      checks++; if ((alu_ready && mem_ready) !== 1'b0) begin errors++; $display("FAIL starve_both_ready[%0d] got=1 exp=0", k); end
      if (k > 0) begin
        checks++; if (write_sig !== 1'b1) begin errors++; $display("FAIL starve_write_sig[%0d] got=%b exp=1", k, write_sig); end
        checks++; if (write_reg !== (prev_alu ? 5'd10 : 5'd11)) begin errors++; $display("FAIL starve_write_reg[%0d] got=%0d exp=%0d", k, write_reg, prev_alu ? 10 : 11); end
      end
      prev_alu = exp_alu;
      next_cycle();
      if (k == 4) alu_valid = 1'b0;
    end
    drive_idle();
  endtask

  task automatic test_x0_illegal();
    next_cycle();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_val = 64'hDEAD;
    @(negedge clk);
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL x0_ready got=%b exp=1", alu_ready); end
    next_cycle();
    alu_valid = 1'b0;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 64'hFFFF; mem_funct3 = 3'b111;
    @(negedge clk);
    checks++; if (write_sig !== 1'b0) begin errors++; $display("FAIL x0_write_sig got=%b exp=0", write_sig); end
    checks++; if (write_reg !== 5'd11) begin errors++; $display("FAIL x0_write_reg_hold got=%0d exp=11", write_reg); end
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL illegal_ready got=%b exp=1", mem_ready); end
    next_cycle();
    drive_idle();
    @(negedge clk);
    checks++; if (write_sig !== 1'b0) begin errors++; $display("FAIL illegal_write_sig got=%b exp=0", write_sig); end
    checks++; if (write_val !== 64'h55) begin errors++; $display("FAIL illegal_write_val_hold got=%h exp=55", write_val); end
  endtask

  task automatic test_reset_mid();
    next_cycle();
    alu_valid = 1'b1; alu_rd = 5'd12; alu_val = 64'hC;
    mem_valid = 1'b1; mem_rd = 5'd13; mem_data = 64'hD; mem_funct3 = 3'b011;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL rmid_pre_mem_ready[%0d] got=%b exp=1", k, mem_ready); end
      next_cycle();
    end
    // Starvation counter is now at its limit; the ALU would win this cycle.
    reset = 1'b1;
    @(negedge clk);
    checks++; if ((alu_ready | mem_ready) !== 1'b0) begin errors++; $display("FAIL rmid_ready_in_reset got=%b%b exp=00", alu_ready, mem_ready); end
    next_cycle();
    @(negedge clk);
    checks++; if (write_sig !== 1'b0) begin errors++; $display("FAIL rmid_write_sig got=%b exp=0", write_sig); end
    checks++; if (write_val !== 64'd0) begin errors++; $display("FAIL rmid_write_val got=%h exp=0", write_val); end
    checks++; if ((alu_ready | mem_ready) !== 1'b0) begin errors++; $display("FAIL rmid_ready_in_reset2 got=%b%b exp=00", alu_ready, mem_ready); end
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL rmid_post_mem_ready got=%b exp=1", mem_ready); end
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL rmid_post_alu_ready got=%b exp=0", alu_ready); end
    next_cycle();
    drive_idle();
    @(negedge clk);
    checks++; if (write_reg !== 5'd13) begin errors++; $display("FAIL rmid_post_write_reg got=%0d exp=13", write_reg); end
  endtask

`ifdef WB_STATS_EN
  task automatic test_stats();
    logic [4:0] rd_tab[3] = '{5'd1, 5'd0, 5'd2};
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_rd = rd_tab[i]; alu_val = 64'(i);
      next_cycle();
    end
    alu_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_valid = 1'b1; mem_rd = 5'(3 + i); mem_data = 64'h9; mem_funct3 = 3'b011;
      next_cycle();
    end
    drive_idle();
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++; if (alu_wr_count !== 32'd2) begin errors++; $display("FAIL stats_alu got=%0d exp=2", alu_wr_count); end
    checks++; if (mem_wr_count !== 32'd2) begin errors++; $display("FAIL stats_mem got=%0d exp=2", mem_wr_count); end
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (alu_wr_count !== 32'd0) begin errors++; $display("FAIL stats_alu_reset got=%0d exp=0", alu_wr_count); end
    checks++; if (mem_wr_count !== 32'd0) begin errors++; $display("FAIL stats_mem_reset got=%0d exp=0", mem_wr_count); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_single_alu();
    test_load_extraction();
    test_back_to_back();
    test_starvation();
    test_x0_illegal();
    test_reset_mid();
`ifdef WB_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage directly upstream of the 32x64 register file.
- Merges results from two producers, the ALU and the load unit, onto the register file's single write port (write_sig / write_reg / write_val).
- Extracts and sign/zero-extends load data.
- Fixed priority favours loads; an anti-starvation counter guarantees ALU progress.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles an ALU request may lose arbitration before it is forced to win. Legal range is 1..15.
- CNT_W, 32: width of the statistics counters (used only with WB_STATS_EN).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result available.
- alu_rd  in  5  ALU destination register.
- alu_val  in  64  ALU result.
- alu_ready  out  1  ALU result accepted this cycle.
- mem_valid  in  1  load data available.
- mem_rd  in  5  load destination register.
- mem_data  in  64  raw aligned 64-bit doubleword from memory.
- mem_funct3  in  3  RV64 load funct3.
- mem_offset  in  3  byte address bits [2:0] of the load.
- mem_ready  out  1  load accepted this cycle.
- write_sig  out  1  register-file write enable.
- write_reg  out  5  register-file write index.
- write_val  out  64  register-file write data.

Behaviour:
- Handshake:
  - A transfer occurs on a source when valid && ready in the same cycle.
  - A producer holds valid, rd and data stable until it is accepted.
  - ready is combinational from valid and the arbiter state only. It never depends on data.
  - At most one of alu_ready / mem_ready is high in any cycle.
- Arbitration:
  - Only one source valid: that source is granted.
  - Both valid: mem is granted, unless starve_cnt == STARVE_LIMIT, in which case alu is granted.
- Starvation counter (starve_cnt, 4 bits):
  - Increments each cycle alu_valid=1 and alu is not granted, saturating at STARVE_LIMIT.
  - Clears to 0 whenever alu is granted or alu_valid=0.
- Output register:
  - Outputs are registered; latency from accept edge to write_sig is exactly 1 cycle.
  - Cycle after a transfer: write_sig=1, write_reg=rd, write_val=result.
  - Otherwise write_sig=0; write_reg and write_val hold their previous values.
- x0 filter: a transfer with rd==0 is accepted (ready asserted) but produces write_sig=0 the next cycle.
- Throughput: one write per cycle. Consecutive grants give back-to-back write_sig pulses.
- Load extraction (byte lane selected from mem_offset, low offset bits below access size ignored):
  - 000 LB: byte[offset], sign-extended.
  - 100 LBU: byte[offset], zero-extended.
  - 001 LH: halfword[offset[2:1]], sign-extended.
  - 101 LHU: halfword[offset[2:1]], zero-extended.
  - 010 LW: word[offset[2]], sign-extended.
  - 110 LWU: word[offset[2]], zero-extended.
  - 011 LD: full 64 bits, offset ignored.
  - 111 (illegal): accepted, write_sig=0 next cycle.
- Reset:
  - While reset=1: alu_ready=0, mem_ready=0, and no transfer occurs.
  - Next edge sets write_sig=0, write_reg=0, write_val=0, starve_cnt=0.
  - Reset mid-stream discards any pending, not-yet-written result.
  - Producers' held requests are re-arbitrated from a cleared counter after reset drops.

Optional Feature:
- Macro WB_STATS_EN.
- Defined:
  - Adds outputs alu_wr_count (CNT_W) and mem_wr_count (CNT_W).
  - Each increments by 1 on every cycle write_sig=1 whose result came from that source.
  - Both cleared by reset; both saturate at all-ones.
  - rd==0 and funct3=111 transfers are not counted.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single ALU write: alu_valid=1, rd=5, val=64'h1234 for one cycle -> alu_ready=1 that cycle; next cycle write_sig=1, write_reg=5, write_val=64'h1234; the cycle after, write_sig=0.
- Load extraction: mem_data=64'h8877_6655_4433_2211, rd=3:
  - LB offset=7 -> write_val=64'hFFFF_FFFF_FFFF_FF88.
  - LBU offset=7 -> 64'h88.
  - LHU offset=2 -> 64'h4433.
  - LW offset=4 -> 64'hFFFF_FFFF_8877_6655.
  - LD -> unchanged.
- Priority and starvation (STARVE_LIMIT=4): both valid continuously, distinct rd -> mem granted 4 consecutive cycles, alu granted on the 5th, then mem resumes. At no point are both readies high.
- x0 and illegal funct3: alu rd=0, val=64'hDEAD -> alu_ready=1, write_sig stays 0. Load with funct3=111 -> mem_ready=1, write_sig stays 0.
- Reset mid-operation: assert reset the cycle a load is accepted -> next cycle write_sig=0, write_val=0; both readies are 0 throughout reset; after release with both valid, mem is granted first.
- WB_STATS_EN: 3 ALU writes (one to rd=0) and 2 loads -> alu_wr_count=2, mem_wr_count=2; reset -> both 0.
